// File: rtl/params_pkg.sv
// Shared parameters for the Barrett reduction block (Dilithium field).
package params_pkg;
  parameter int DATA_LENGTH    = 64;
  parameter int MODULUS        = 8380417;   // 2^23 - 2^13 + 1
  parameter int MODULUS_LENGTH = 23;
  parameter int MU             = 8396807;   // floor(4^23 / MODULUS)
endpackage

// File: rtl/barrett_iterative.sv
// Iterative Barrett reduction: result = x mod m, fixed latency.
// Two shift-add multiplies share one MUL_STEP-bit-per-cycle multiplier,
// followed by a subtract and two unconditional correction cycles.
// Optional: define BARRETT_RANGE_CHECK_EN to add range_err_o, which flags
// x >= 4^k and forces the result to zero.
module barrett_iterative #(
  parameter int DATA_LENGTH = params_pkg::DATA_LENGTH,
  parameter int MUL_STEP    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] mu_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic                   busy_o,
  output logic                   finish_o,
  output logic [DATA_LENGTH-1:0] result_o
`ifdef BARRETT_RANGE_CHECK_EN
 ,output logic                   range_err_o
`endif
);

  localparam int N  = DATA_LENGTH / MUL_STEP;
  localparam int AW = 2 * DATA_LENGTH;
  localparam int RW = DATA_LENGTH + 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, SUB, CORR1, CORR2, DONE} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [DATA_LENGTH-1:0] x_q, m_q, k_q;
  logic [AW-1:0]          acc, mcand;
  logic [DATA_LENGTH-1:0] mplier;
  logic [RW-1:0]          r;
  logic [DATA_LENGTH-1:0] result_q;

  logic [MUL_STEP-1:0]    digit;
  logic [AW-1:0]          acc_sum, q2_shift;
  logic [RW-1:0]          r_sub, r_corr;
  logic [DATA_LENGTH-1:0] res_nxt;
  logic                   cnt_last;

  // Shared multiplier step, subtract and conditional correction
  always_comb begin
    digit    = mplier[MUL_STEP-1:0];
    acc_sum  = acc + mcand * AW'(digit);
    q2_shift = acc_sum >> (k_q + DATA_LENGTH'(1));
    cnt_last = (cnt == CW'(N - 1));
    r_sub    = RW'(x_q) - acc[RW-1:0];
    r_corr   = (r >= RW'(m_q)) ? (r - RW'(m_q)) : r;
    res_nxt  = r_corr[DATA_LENGTH-1:0];
  end

`ifdef BARRETT_RANGE_CHECK_EN
  logic err_q, over;
  // x >= 4^k is outside the exact range of the reduction
  always_comb over = ((x_q >> (k_q << 1)) != '0);
  assign range_err_o = err_q;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    finish_o  = 1'b0;
    unique case (state)
      IDLE:  if (start_i) state_nxt = MUL1;
      MUL1:  begin busy_o = 1'b1; if (cnt_last) state_nxt = MUL2; end
      MUL2:  begin busy_o = 1'b1; if (cnt_last) state_nxt = SUB;  end
      SUB:   begin busy_o = 1'b1; state_nxt = CORR1; end
      CORR1: begin busy_o = 1'b1; state_nxt = CORR2; end
      CORR2: begin busy_o = 1'b1; state_nxt = DONE;  end
      DONE:  begin finish_o = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, multiplier iteration, subtract/correct and result hold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      x_q      <= '0;
      m_q      <= '0;
      k_q      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      r        <= '0;
      result_q <= '0;
`ifdef BARRETT_RANGE_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (start_i) begin
          x_q    <= x_i;
          m_q    <= m_i;
          k_q    <= m_bl_i;
          // first multiply: (x >> (k-1)) * mu
          mcand  <= AW'(x_i >> (m_bl_i - DATA_LENGTH'(1)));
          mplier <= mu_i;
          acc    <= '0;
          cnt    <= '0;
`ifdef BARRETT_RANGE_CHECK_EN
          err_q  <= 1'b0;
`endif
        end
        MUL1: begin
          cnt <= cnt + CW'(1);
          if (cnt_last) begin
            // second multiply: (q2 >> (k+1)) * m
            cnt    <= '0;
            acc    <= '0;
            mcand  <= q2_shift;
            mplier <= m_q;
          end else begin
            acc    <= acc_sum;
            mcand  <= mcand << MUL_STEP;
            mplier <= mplier >> MUL_STEP;
          end
        end
        MUL2: begin
          acc    <= acc_sum;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          cnt    <= cnt_last ? '0 : cnt + CW'(1);
        end
        SUB:   r <= r_sub;
        CORR1: r <= r_corr;
        CORR2: begin
          r <= r_corr;
`ifdef BARRETT_RANGE_CHECK_EN
          err_q    <= over;
          result_q <= over ? '0 : res_nxt;
`else
          result_q <= res_nxt;
`endif
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_barrett_iterative.sv
// Scoreboard bench for barrett_iterative: a 32-bit instance (m=13) and a
// default-width instance on the Dilithium modulus.
module tb_barrett_iterative;
  localparam int DLA = 32;
  localparam int NA  = 8;
  localparam int DLB = params_pkg::DATA_LENGTH;
  localparam int NB  = DLB / 4;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic           start_a = 1'b0, busy_a, fin_a;
  logic [DLA-1:0] x_a = '0, m_a = '0, mu_a = '0, k_a = '0, res_a;
  logic           start_b = 1'b0, busy_b, fin_b;
  logic [DLB-1:0] x_b = '0, m_b = '0, mu_b = '0, k_b = '0, res_b;
  logic           pa = 1'b0, pb = 1'b0;
`ifdef BARRETT_RANGE_CHECK_EN
  logic err_a, err_b;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  barrett_iterative #(.DATA_LENGTH(DLA), .MUL_STEP(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .x_i(x_a), .m_i(m_a),
    .mu_i(mu_a), .m_bl_i(k_a), .busy_o(busy_a), .finish_o(fin_a),
    .result_o(res_a)
`ifdef BARRETT_RANGE_CHECK_EN
   ,.range_err_o(err_a)
`endif
  );

  barrett_iterative dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .x_i(x_b), .m_i(m_b),
    .mu_i(mu_b), .m_bl_i(k_b), .busy_o(busy_b), .finish_o(fin_b),
    .result_o(res_b)
`ifdef BARRETT_RANGE_CHECK_EN
   ,.range_err_o(err_b)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor A: pop expected entry on every finish pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && fin_a) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_finish: got result %0d, expected no finish", res_a);
      end else begin
        e = qa.pop_front();
        chk("a_result", res_a, e.res);
        chk("a_latency", 64'(cyc), 64'(e.cyc));
        chk("a_busy_at_finish", 64'(busy_a), 64'd0);
`ifdef BARRETT_RANGE_CHECK_EN
        chk("a_range_err", 64'(err_a), 64'(e.err));
`endif
      end
      chk("a_single_pulse", 64'(pa), 64'd0);
    end
    pa = fin_a;
  end

  // Monitor B: same checks for the Dilithium instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && fin_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_finish: got result %0d, expected no finish", res_b);
      end else begin
        e = qb.pop_front();
        chk("b_result", res_b, e.res);
        chk("b_latency", 64'(cyc), 64'(e.cyc));
`ifdef BARRETT_RANGE_CHECK_EN
        chk("b_range_err", 64'(err_b), 64'(e.err));
`endif
      end
    end
    pb = fin_b;
  end

  task automatic go_a(input logic [31:0] x, input logic [63:0] r, input logic er);
    int n = 0;
    while ((busy_a || fin_a) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("a_idle_timeout", 64'(busy_a), 64'd0);
    x_a = x; start_a = 1'b1;
    qa.push_back('{r, cyc + 2*NA + 4, er});
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic go_b(input logic [63:0] x, input logic [63:0] r);
    int n = 0;
    while ((busy_b || fin_b) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("b_idle_timeout", 64'(busy_b), 64'd0);
    x_b = DLB'(x); start_b = 1'b1;
    qb.push_back('{r, cyc + 2*NB + 4, 1'b0});
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 400) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("a_pending_results", 64'(qa.size()), 64'd0);
  endtask

  // Dilithium vectors on instance B
  initial begin
    m_b = DLB'(params_pkg::MODULUS);
    mu_b = DLB'(params_pkg::MU);
    k_b = DLB'(params_pkg::MODULUS_LENGTH);
    @(posedge rst_n);
    @(negedge clk);
    go_b(64'd8380417,   64'd0);
    go_b(64'd8380416,   64'd8380416);
    go_b(64'd8380418,   64'd1);
    go_b(64'd16760834,  64'd0);
    go_b(64'd100000000, 64'd7815413);
    go_b(64'd0,         64'd0);
  end

  // Main sequence on instance A
  initial begin
    m_a = 32'd13; k_a = 32'd4; mu_a = 32'd19;
    repeat (3) @(negedge clk);
    chk("reset_busy_a",   64'(busy_a), 64'd0);
    chk("reset_finish_a", 64'(fin_a),  64'd0);
    chk("reset_result_a", 64'(res_a),  64'd0);
    chk("reset_result_b", 64'(res_b),  64'd0);
    rst_n = 1'b1;

    // directed values, back-to-back
    go_a(32'd200, 64'd5,  1'b0);
    go_a(32'd255, 64'd8,  1'b0);
    go_a(32'd12,  64'd12, 1'b0);
    go_a(32'd13,  64'd0,  1'b0);
    go_a(32'd0,   64'd0,  1'b0);
    go_a(32'd26,  64'd0,  1'b0);
    go_a(32'd38,  64'd12, 1'b0);
    go_a(32'd100, 64'd9,  1'b0);
    drain_a();

    // start pulses while busy are dropped
    go_a(32'd200, 64'd5, 1'b0);
    repeat (2) @(negedge clk);
    x_a = 32'd255; start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (6) @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    drain_a();
    repeat (25) @(negedge clk);

    // start held high: one operation every 2N+5 cycles
    x_a = 32'd100; start_a = 1'b1;
    for (int i = 0; i < 3; i++) qa.push_back('{64'd9, cyc + 2*NA + 4 + i*(2*NA + 5), 1'b0});
    repeat (2*(2*NA + 5) + 1) @(negedge clk);
    start_a = 1'b0;
    drain_a();

    // x changed after acceptance
    go_a(32'd255, 64'd8, 1'b0);
    repeat (5) @(negedge clk);
    x_a = 32'd200;
    drain_a();

    // reset in MUL2 aborts the operation
    go_a(32'd200, 64'd5, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   64'(busy_a), 64'd0);
    chk("abort_finish", 64'(fin_a),  64'd0);
    chk("abort_result", 64'(res_a),  64'd0);
    qa.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go_a(32'd38, 64'd12, 1'b0);
    drain_a();

`ifdef BARRETT_RANGE_CHECK_EN
    go_a(32'd256, 64'd0, 1'b1);
    drain_a();
    go_a(32'd255, 64'd8, 1'b0);
    drain_a();
`endif

    repeat (40) @(negedge clk);
    chk("b_pending_results", 64'(qb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
